fp_int_mac: RTL and testbench
=============================

Name: fp_int_mac

Overview:
Multi-cycle multiply-accumulate for mixed-precision inference: one FP16 activation times one signed INT weight.
- Product is converted to two's-complement fixed point, aligned to a shared block exponent exp_min, and added to a caller-supplied accumulator value.
- Sits inside a dot-product lane. The caller owns the running sum (feeds fixed_point_acc back) and the block exponent.

Parameters:
- ACT_WIDTH, 16: activation width. IEEE FP16 only: sign [15], exponent [14:10], fraction [9:0].
- W_WIDTH, 4: weight width, signed two's complement.
- ACC_WIDTH, 32: accumulator input/output width, signed two's complement.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin operation. Sampled only in IDLE.
- activation  in  ACT_WIDTH  FP16 operand.
- weight  in  W_WIDTH  signed integer operand.
- exp_min  in  5  block exponent (biased FP16 exponent) the result is aligned to.
- fixed_point_acc  in  ACC_WIDTH  signed addend.
- exp_out  out  5  block exponent of fixed_point_out.
- fixed_point_out  out  ACC_WIDTH  signed result.
- done  out  1  one-cycle pulse, result valid.

Behaviour:
Reset:
- rst=1 clears state to IDLE and sets exp_out=0, fixed_point_out=0, done=0 immediately, independent of clk.
- Reset mid-operation discards the operation.

Start and operand capture:
- IDLE with start=1 at a rising edge: latch activation, weight, exp_min and fixed_point_acc, then enter MUL.
- start is ignored while busy. Inputs may change freely after capture.

Operand decode:
- s = activation[15] XOR weight[W_WIDTH-1].
- |w| = magnitude of weight (-8 gives 8).
- Exponent field e != 0: m = {1, fraction} (11 bits), E = e.
- e == 0 (zero or subnormal): m = {0, fraction}, E = 1.
- e == 31 gets no special Inf/NaN handling; it is treated as a normal number.

States:
- MUL: W_WIDTH cycles of shift-add, one weight bit per cycle LSB first, p = m * |w| (unsigned, 11+W_WIDTH bits).
- ALIGN: d = E - exp_min (signed).
  - d >= 0: q = p << d.
  - d < 0: q = p >> -d (truncating; shifts of 15 or more give 0).
  - q is sized ACC_WIDTH; bits above it are lost.
  - Apply the sign: v = s ? -q : q.
- ACC:
  - fixed_point_out <= acc_latched + v, wrapping mod 2^ACC_WIDTH.
  - exp_out <= exp_min_latched.
  - done <= 1. Return to IDLE.

Timing and output hold:
- Latency: start-sample edge to done-high edge is W_WIDTH+2 cycles (6 at default). A new start is accepted the cycle after done.
- fixed_point_out and exp_out hold their value until the next ACC or reset.
- done is low except for the single pulse.

Arithmetic rules:
- weight 0 or activation zero gives v = 0, so out = acc.
- -0.0 × w is treated as 0.

Optional Feature:
- Macro FP_INT_MAC_SATURATE_EN.
  - Defined: final add and the ALIGN left shift saturate to the signed range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any bit lost in a left shift saturates toward s.
  - Undefined: modular wrap as above. Timing is identical in both builds.

Decomposition:
- Package fp_int_mac_pkg:
  - FP16 field positions/widths: SIGN_BIT, EXP_W=5, FRAC_W=10.
  - Denormal effective exponent 1.
  - State enum IDLE/MUL/ALIGN/ACC.
- One sub-module fp_int_mac_serial_mul: the W_WIDTH-cycle unsigned shift-add multiplier with its own start/done.
- Alignment, sign and accumulate stay in the top.

Test Plan:
1. activation=0x4569, weight=3, exp_min=16, acc=2 -> done after 6 cycles, fixed_point_out=0x00002078, exp_out=16.
2. Back-to-back: activation=0x4AAA, weight=5, exp_min=16, acc=2 -> fixed_point_out=0x0000854A, exp_out=16.
3. Signs:
   - activation=0x3C00, weight=4'hF, exp_min=15, acc=0 -> 0xFFFFFC00.
   - activation=0xC000, weight=2, exp_min=16, acc=100 -> 0xFFFFF864.
4. Right shift and subnormal:
   - activation=0x3C00, weight=3, exp_min=17, acc=0 -> 0x00000300.
   - activation=0x0001, weight=7, exp_min=1, acc=5 -> 0x0000000C.
5. rst pulsed during MUL -> outputs 0, done never pulses. Then a fresh start with case 1 values -> 0x00002078.
6. Overflow: activation=0x7BFF, weight=7, exp_min=0, acc=0:
   - Default build -> wrapped value.
   - With FP_INT_MAC_SATURATE_EN -> 0x7FFFFFFF.

Source files
------------

// File: rtl/fp_int_mac_pkg.sv
// Shared FP16 field layout, denormal exponent and FSM encoding for the
// fp_int_mac multiply-accumulate lane.
package fp_int_mac_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int MANT_W   = FRAC_W + 1;

  // Zero and subnormal activations use exponent 1 with a hidden bit of 0.
  localparam logic [EXP_W-1:0] DENORM_EXP = 5'd1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ALIGN,
    ACC
  } state_t;

endpackage

// File: rtl/fp_int_mac_serial_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// B_W cycles after start the full product sits on product.
module fp_int_mac_serial_mul #(
  parameter int A_W = 11,
  parameter int B_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] product,
  output logic               done
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W + 1);

  logic [P_W-1:0]   mcand;
  logic [B_W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  // Handshake: start is a single-cycle request that loads a and b. done is
  // high during the cycle whose closing edge writes the last partial sum, so
  // product is valid from that edge onward and holds until the next start.
  assign done = busy && (cnt == CNT_W'(B_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      mcand   <= P_W'(a);
      mplier  <= b;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_int_mac.sv
// FP16 activation x signed INT weight, aligned to a block exponent and added
// to a caller-held accumulator. Define FP_INT_MAC_SATURATE_EN for saturation.
module fp_int_mac
  import fp_int_mac_pkg::*;
#(
  parameter int ACT_WIDTH = 16,
  parameter int W_WIDTH   = 4,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ACT_WIDTH-1:0] activation,
  input  logic [W_WIDTH-1:0]   weight,
  input  logic [EXP_W-1:0]     exp_min,
  input  logic [ACC_WIDTH-1:0] fixed_point_acc,
  output logic [EXP_W-1:0]     exp_out,
  output logic [ACC_WIDTH-1:0] fixed_point_out,
  output logic                 done
);

  localparam int P_W = MANT_W + W_WIDTH;
`ifdef FP_INT_MAC_SATURATE_EN
  // Wide enough to hold the product after the largest left shift.
  localparam int WIDE_W = ACC_WIDTH + P_W + (1 << EXP_W);
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`else
  localparam int WIDE_W = ACC_WIDTH;
`endif

  state_t state_q, state_d;
  logic   mul_start, mul_done;

  logic [EXP_W-1:0]     act_e, eff_e;
  logic [MANT_W-1:0]    mant;
  logic [W_WIDTH-1:0]   w_mag;
  logic [P_W-1:0]       p;

  logic                 s_q;
  logic [EXP_W-1:0]     e_q, exp_min_q;
  logic [ACC_WIDTH-1:0] acc_q, v_q, v_d, sum_d, q;
  logic                 d_neg;
  logic [EXP_W-1:0]     lshift, rshift;
  logic [WIDE_W-1:0]    wide_l;

  assign act_e = activation[SIGN_BIT-1 -: EXP_W];
  assign eff_e = (act_e == '0) ? DENORM_EXP : act_e;
  assign mant  = {act_e != '0, activation[FRAC_W-1:0]};
  assign w_mag = weight[W_WIDTH-1] ? (~weight + 1'b1) : weight;

  fp_int_mac_serial_mul #(
    .A_W(MANT_W),
    .B_W(W_WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (mant),
    .b      (w_mag),
    .product(p),
    .done   (mul_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mul_start = 1'b1;
          state_d   = MUL;
        end
      end
      MUL:     if (mul_done) state_d = ALIGN;
      ALIGN:   state_d = ACC;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // d = E - exp_min split into direction and magnitude to keep shifts unsigned.
  always_comb begin
    d_neg  = e_q < exp_min_q;
    lshift = e_q - exp_min_q;
    rshift = exp_min_q - e_q;
    wide_l = WIDE_W'(p) << lshift;
    q      = d_neg ? ACC_WIDTH'(p >> rshift) : wide_l[ACC_WIDTH-1:0];
`ifdef FP_INT_MAC_SATURATE_EN
    if ((!d_neg && (|wide_l[WIDE_W-1:ACC_WIDTH])) ||
        (s_q ? (q > SAT_MIN) : (q > SAT_MAX))) begin
      v_d = s_q ? SAT_MIN : SAT_MAX;
    end else begin
      v_d = s_q ? (~q + 1'b1) : q;
    end
`else
    v_d = s_q ? (~q + 1'b1) : q;
`endif
  end

`ifdef FP_INT_MAC_SATURATE_EN
  logic [ACC_WIDTH:0] sum_ext;
  always_comb begin
    sum_ext = {acc_q[ACC_WIDTH-1], acc_q} + {v_q[ACC_WIDTH-1], v_q};
    sum_d   = sum_ext[ACC_WIDTH-1:0];
    if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
      sum_d = sum_ext[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign sum_d = acc_q + v_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q             <= 1'b0;
      e_q             <= '0;
      exp_min_q       <= '0;
      acc_q           <= '0;
      v_q             <= '0;
      exp_out         <= '0;
      fixed_point_out <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mul_start) begin
        s_q       <= activation[SIGN_BIT] ^ weight[W_WIDTH-1];
        e_q       <= eff_e;
        exp_min_q <= exp_min;
        acc_q     <= fixed_point_acc;
      end
      if (state_q == ALIGN) begin
        v_q <= v_d;
      end
      if (state_q == ACC) begin
        fixed_point_out <= sum_d;
        exp_out         <= exp_min_q;
        done            <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_int_mac.sv
// Directed and randomized checks of fp_int_mac against an arithmetic model;
// follows FP_INT_MAC_SATURATE_EN for the expected overflow behaviour.
module tb_fp_int_mac;

  localparam int LATENCY = 6;
  localparam int BUDGET  = 20;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] activation;
  logic [3:0]  weight;
  logic [4:0]  exp_min;
  logic [31:0] fixed_point_acc;
  logic [4:0]  exp_out;
  logic [31:0] fixed_point_out;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  fp_int_mac dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .activation     (activation),
    .weight         (weight),
    .exp_min        (exp_min),
    .fixed_point_acc(fixed_point_acc),
    .exp_out        (exp_out),
    .fixed_point_out(fixed_point_out),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value of the product scaled by 2^(E - exp_min), signed, then added to acc.
  function automatic logic [31:0] ref_mac(input logic [15:0] a, input logic [3:0] w,
                                          input logic [4:0] em, input logic [31:0] ac);
    int e, ee, wv, mant, d;
    longint p, q, v, r;
    e    = int'(a[14:10]);
    ee   = (e == 0) ? 1 : e;
    mant = int'(a[9:0]) + ((e != 0) ? 1024 : 0);
    wv   = int'($signed(w));
    p    = longint'(mant) * longint'((wv < 0) ? -wv : wv);
    d    = ee - int'(em);
    if (d >= 0) q = p * (longint'(1) << d);
    else        q = p / (longint'(1) << (-d));
    v = ((a[15] == 1'b1) != (wv < 0)) ? -q : q;
`ifdef FP_INT_MAC_SATURATE_EN
    if (v > 64'sd2147483647)  v = 64'sd2147483647;
    if (v < -64'sd2147483648) v = -64'sd2147483648;
    r = longint'($signed(ac)) + v;
    if (r > 64'sd2147483647)  r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
`else
    r = longint'($signed(ac)) + v;
`endif
    return r[31:0];
  endfunction

  // Called #1 after a rising edge; start is sampled at the next edge.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [3:0] w,
                        input logic [4:0] em, input logic [31:0] ac, input logic [31:0] exp_val);
    int cyc;
    activation      = a;
    weight          = w;
    exp_min         = em;
    fixed_point_acc = ac;
    start           = 1'b1;
    @(posedge clk);
    #1;
    start           = 1'b0;
    activation      = 16'($urandom);
    weight          = 4'($urandom);
    exp_min         = 5'($urandom);
    fixed_point_acc = $urandom;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      start = done ? 1'b0 : 1'($urandom_range(0, 1));
    end while (!done && cyc < BUDGET);
    start = 1'b0;
    check({tag, ".latency"}, 32'(cyc), 32'(LATENCY));
    check({tag, ".out"}, fixed_point_out, exp_val);
    check({tag, ".exp"}, {27'd0, exp_out}, {27'd0, em});
  endtask

  initial begin
    int done_cnt;
    logic [31:0] held;
    logic [15:0] ra;
    logic [3:0]  rw;
    logic [4:0]  re;
    logic [31:0] rc;

    rst = 1'b0;
    start = 1'b0;
    activation = '0;
    weight = '0;
    exp_min = '0;
    fixed_point_acc = '0;
    #1 rst = 1'b1;
    #2;
    check("reset.out", fixed_point_out, 32'h0);
    check("reset.exp", {27'd0, exp_out}, 32'h0);
    check("reset.done", {31'd0, done}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    run_op("case1", 16'h4569, 4'd3, 5'd16, 32'd2, 32'h0000_2078);
    run_op("case2", 16'h4AAA, 4'd5, 5'd16, 32'd2, 32'h0000_854A);
    run_op("neg_w", 16'h3C00, 4'hF, 5'd15, 32'd0, 32'hFFFF_FC00);
    run_op("neg_a", 16'hC000, 4'd2, 5'd16, 32'd100, 32'hFFFF_F864);
    run_op("rshift", 16'h3C00, 4'd3, 5'd17, 32'd0, 32'h0000_0300);
    run_op("subnorm", 16'h0001, 4'd7, 5'd1, 32'd5, 32'h0000_000C);
    run_op("w_min", 16'h3C00, 4'h8, 5'd15, 32'd0, 32'hFFFF_E000);
    run_op("neg_zero", 16'h8000, 4'd5, 5'd3, 32'h1234_5678, 32'h1234_5678);
    run_op("w_zero", 16'h4569, 4'd0, 5'd16, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_op("rs_far", 16'h07FF, 4'd7, 5'd31, 32'd9, 32'd9);

    // Reset in the middle of a multiply discards it.
    activation = 16'h4569;
    weight = 4'd3;
    exp_min = 5'd16;
    fixed_point_acc = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("midrst.out", fixed_point_out, 32'h0);
    check("midrst.exp", {27'd0, exp_out}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("midrst.no_done", 32'(done_cnt), 32'd0);
    run_op("after_rst", 16'h4569, 4'd3, 5'd16, 32'd2, 32'h0000_2078);

`ifdef FP_INT_MAC_SATURATE_EN
    run_op("overflow", 16'h7BFF, 4'd7, 5'd0, 32'd0, 32'h7FFF_FFFF);
`else
    run_op("overflow", 16'h7BFF, 4'd7, 5'd0, 32'd0, 32'h4000_0000);
`endif

    held = fixed_point_out;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    check("hold.out", fixed_point_out, held);
    check("hold.done", {31'd0, done}, 32'h0);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rw = 4'($urandom);
      re = 5'($urandom_range(0, 31));
      rc = $urandom;
      run_op("rand", ra, rw, re, rc, ref_mac(ra, rw, re, rc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
